// File: rtl/note_envelope.sv
// ADSR envelope stage for one track: detects note-on/off/retrigger on the raw
// {tuneWord, volume} packet and scales the volume by an attack/decay/sustain/release envelope.
module note_envelope #(
    parameter logic [15:0] ATTACK_STEP   = 16'h0100,
    parameter logic [15:0] DECAY_STEP    = 16'h0010,
    parameter logic [7:0]  SUSTAIN_LEVEL = 8'hC0,
    parameter logic [15:0] RELEASE_STEP  = 16'h0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [23:0] inPacket,
    output logic [23:0] outPacket,
    output logic [2:0]  envState,
    output logic        active
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    env_state_t  state_q, state_d;
    logic [15:0] env_q, env_d;
    logic [15:0] held_tune_q, held_tune_d;
    logic [7:0]  held_vol_q, held_vol_d;
    logic [15:0] prev_tune_q, prev_tune_d;
    logic [23:0] out_packet_q, out_packet_d;
    logic        active_q, active_d;

    logic [15:0] in_tune;
    logic [7:0]  in_vol;
    logic        note_on;
    logic        is_event;
    logic        clear_held;
    logic [16:0] attack_sum;
    logic [16:0] decay_diff;
    logic [16:0] release_diff;
    logic [15:0] sustain_floor;
    logic [15:0] vol_product;
    logic [7:0]  shaped_vol;

    // Arithmetic is done one bit wider so carry/borrow can be used as saturation flags.
    always_comb begin
        in_tune       = inPacket[23:8];
        in_vol        = inPacket[7:0];
        note_on       = (in_tune != 16'd0) && (in_vol != 8'd0);
        attack_sum    = {1'b0, env_q} + {1'b0, ATTACK_STEP};
        decay_diff    = {1'b0, env_q} - {1'b0, DECAY_STEP};
        release_diff  = {1'b0, env_q} - {1'b0, RELEASE_STEP};
        sustain_floor = {SUSTAIN_LEVEL, 8'h00};
        vol_product   = {8'h00, env_q[15:8]} * {8'h00, held_vol_q};
        shaped_vol    = 8'((vol_product + 16'd255) >> 8);
    end

    always_comb begin
        state_d     = state_q;
        env_d       = env_q;
        held_tune_d = held_tune_q;
        held_vol_d  = held_vol_q;
        prev_tune_d = in_tune;
        is_event    = 1'b0;
        clear_held  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (note_on) begin
                    state_d  = ST_ATTACK;
                    is_event = 1'b1;
                end
            end
            ST_ATTACK, ST_DECAY, ST_SUSTAIN: begin
                if (!note_on) begin
                    state_d  = ST_RELEASE;
                    is_event = 1'b1;
                end else if (in_tune != prev_tune_q) begin
                    state_d  = ST_ATTACK;
                    is_event = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (note_on) begin
                    state_d  = ST_ATTACK;
                    is_event = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An event in the same clk as a tick takes priority; env holds that cycle.
        if (!is_event && tick) begin
            case (state_q)
                ST_ATTACK: begin
                    if ((ATTACK_STEP == 16'd0) || attack_sum[16] || (attack_sum[15:0] == 16'hFFFF)) begin
                        env_d   = 16'hFFFF;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = attack_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    if ((DECAY_STEP == 16'd0) || decay_diff[16] || (decay_diff[15:0] <= sustain_floor)) begin
                        env_d   = sustain_floor;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = decay_diff[15:0];
                    end
                end
                ST_RELEASE: begin
                    if ((RELEASE_STEP == 16'd0) || release_diff[16] || (release_diff[15:0] == 16'd0)) begin
                        env_d      = 16'd0;
                        state_d    = ST_IDLE;
                        clear_held = 1'b1;
                    end else begin
                        env_d = release_diff[15:0];
                    end
                end
                default: env_d = env_q;
            endcase
        end

        // Held note freezes while the host is silent so the release tail keeps its pitch.
        if (note_on) begin
            held_tune_d = in_tune;
            held_vol_d  = in_vol;
        end else if (clear_held) begin
            held_tune_d = 16'd0;
            held_vol_d  = 8'd0;
        end

        out_packet_d = (state_q == ST_IDLE) ? 24'h0 : {held_tune_q, shaped_vol};
        active_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            env_q        <= 16'd0;
            held_tune_q  <= 16'd0;
            held_vol_q   <= 8'd0;
            prev_tune_q  <= 16'd0;
            out_packet_q <= 24'h0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            env_q        <= env_d;
            held_tune_q  <= held_tune_d;
            held_vol_q   <= held_vol_d;
            prev_tune_q  <= prev_tune_d;
            out_packet_q <= out_packet_d;
            active_q     <= active_d;
        end
    end

    assign outPacket = out_packet_q;
    assign envState  = state_q;
    assign active    = active_q;

endmodule

// File: doc/note_envelope.md
Name: note_envelope

Overview:
ADSR envelope stage between spi and noteCore, one instance per track. Consumes the raw 24-bit note packet {tuneWord[23:8], volume[7:0]} and detects note-on, note-off and retrigger events. Emits a packet in the same format whose volume field is the requested volume scaled by an attack/decay/sustain/release envelope. This removes clicks at note boundaries and lets notes ring out after the host silences them.

Parameters:
ATTACK_STEP, 16'h0100, envelope increment per tick in ATTACK; 0 = jump to full instantly
DECAY_STEP, 16'h0010, envelope decrement per tick in DECAY; 0 = jump to sustain instantly
SUSTAIN_LEVEL, 8'hC0, sustain envelope level (upper byte; floor = SUSTAIN_LEVEL<<8)
RELEASE_STEP, 16'h0008, envelope decrement per tick in RELEASE; 0 = jump to 0 instantly

Ports:
clk  in  1  system clock (40 MHz)
reset  in  1  synchronous, active-high
tick  in  1  envelope step strobe, one clk wide (noteCore wgEn rate, 156.25 kHz)
inPacket  in  24  raw packet from spi: [23:8] tuneWord, [7:0] volume
outPacket  out  24  shaped packet to noteCore: [23:8] tuneWord, [7:0] shaped volume
envState  out  3  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
active  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, env=16'h0000, heldTune=0, heldVol=0, outPacket=0, envState=0, active=0. Reset mid-note aborts immediately. No release tail.
- noteOn  = (inPacket[23:8]!=0) & (inPacket[7:0]!=0).
- prevTune = registered inPacket[23:8], sampled every clk.
- Events are evaluated every clk, independent of tick:
  - IDLE & noteOn -> ATTACK. env is not cleared (it is already 0).
  - ATTACK/DECAY/SUSTAIN & ~noteOn -> RELEASE.
  - RELEASE & noteOn -> ATTACK, starting from the current env (no jump to 0).
  - ATTACK/DECAY/SUSTAIN & noteOn & inPacket[23:8]!=prevTune -> ATTACK (retrigger) from the current env.
  - A volume-only change does not retrigger. heldVol follows it immediately.
- heldTune/heldVol load from inPacket on every clk where noteOn=1. They freeze while noteOn=0, so RELEASE keeps sounding the last note.
- Envelope stepping occurs only on a clk with tick=1 and no event in that clk. If an event and a tick coincide, the event wins and env is unchanged that cycle.
- ATTACK: env_next = env + ATTACK_STEP, computed 17-bit.
  - Carry or result 16'hFFFF -> env=16'hFFFF, go to DECAY.
  - ATTACK_STEP=0 -> env=16'hFFFF and DECAY on the next tick.
- DECAY: floor = {SUSTAIN_LEVEL,8'h00}.
  - If env - DECAY_STEP <= floor (borrow included) -> env=floor, go to SUSTAIN.
  - DECAY_STEP=0 behaves as an infinite step.
  - If env is already <= floor on entry, clamp to floor and go to SUSTAIN on the first tick.
- SUSTAIN: env held at floor. It does not track later parameter changes (parameters are static).
- RELEASE: env - RELEASE_STEP with borrow or result 0 -> env=0, go to IDLE, heldTune/heldVol cleared. RELEASE_STEP=0 behaves as an infinite step.
- Volume arithmetic: shaped = (env[15:8]*heldVol + 8'd255) >> 8, 16-bit product.
  - env[15:8]=255 gives exactly heldVol.
  - env[15:8]=0 gives 0.
  - The result never exceeds heldVol.
- outPacket register, updated every clk:
  - IDLE: 24'h0.
  - Otherwise: {heldTune, shaped}.
  - Latency: one clk from the env/state register to outPacket, two clk from inPacket to the first state change seen on outPacket.
- envState and active are registered state outputs. They have no extra lag relative to state.
- The inPacket change rate is not constrained. Back-to-back events on consecutive clks are legal, and each one is evaluated.

Test Plan:
- Reset held 4 clk with inPacket=24'h1234C8 -> outPacket=0, envState=0, active=0 throughout. Then release reset.
- ATTACK_STEP=16'h1000, tick every 256 clk, inPacket=24'h1234FF -> ATTACK. env reaches 16'hF000 after 15 ticks and saturates to 16'hFFFF on tick 16, entering DECAY. outPacket then = 24'h1234FF.
- DECAY_STEP=16'h0800, SUSTAIN_LEVEL=8'h80, volume 8'hC8 -> SUSTAIN entered on the 16th DECAY tick with env=16'h8000. outPacket[7:0]=8'd100, tune held at 16'h1234.
- From SUSTAIN, inPacket=24'h0 with RELEASE_STEP=16'h1000 -> RELEASE. outPacket keeps tune 16'h1234 and the volume falls on each tick. IDLE on tick 8, then outPacket=0 and active=0.
- Retrigger: in SUSTAIN change inPacket to 24'h2000C8 -> ATTACK from env=16'h8000, not 0. outPacket tune=16'h2000 two clk later. Repeat with a volume-only change to 24'h200064 -> stays in SUSTAIN, shaped volume=8'd50.
- Coincidence and zero steps: an event in the same clk as tick leaves env unchanged that cycle. With ATTACK_STEP=0 and DECAY_STEP=0, one tick takes env to 16'hFFFF and the next tick to SUSTAIN.
